// File: rtl/hardsigmoid_pkg.sv
// Shared fixed-point constants for the HardSigmoid forward and backward blocks.
// All Q16.16 values are signed 32-bit; INV6_Q16 is 1/6 in Q0.16.
package hardsigmoid_pkg;

   localparam int FRAC_W = 16;
   localparam int Q_W    = 32;

   localparam logic signed [Q_W-1:0] Q_POS3 = 32'sh0003_0000;
   localparam logic signed [Q_W-1:0] Q_NEG3 = 32'shFFFD_0000;
   localparam logic signed [Q_W-1:0] Q_ONE  = 32'sh0001_0000;

   // 1/6 rounded to 16 fractional bits (10923)
   localparam logic signed [15:0] INV6_Q16 = 16'sh2AAB;

   // Half an LSB of the product before dropping FRAC_W bits
   localparam logic [Q_W-1:0] RND_HALF = 32'h0000_8000;

   // Beat payload as it leaves the first stage
   typedef struct packed {
      logic signed [Q_W-1:0] dy;
      logic                  mask;
   } s1_beat_t;

endpackage

// File: rtl/fxp_mul_round.sv
// Signed DATA_W x COEF_W multiply with a registered full-precision product and
// a round-half-up (toward +inf) shift back to DATA_W bits.
module fxp_mul_round
   import hardsigmoid_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int COEF_W = 16,
   parameter int FRAC_W = 16
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a_p1,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [DATA_W-1:0] rnd_p2
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [PROD_W-1:0] HALF = PROD_W'(RND_HALF);

   logic signed [PROD_W-1:0] prod_p2;

   // Add half an LSB then arithmetic shift; the 1/6 coefficient keeps the
   // result inside DATA_W so plain truncation is exact.
   function automatic logic signed [DATA_W-1:0] round_half_up(
      input logic signed [PROD_W-1:0] prod
   );
      return DATA_W'((prod + HALF) >>> FRAC_W);
   endfunction

   // ---- S1 -> S2 boundary: full-precision product register
   always_ff @(posedge clk) begin
      if (en) begin
         prod_p2 <= PROD_W'(a_p1) * PROD_W'(coef);
      end
   end

   assign rnd_p2 = round_half_up(prod_p2);

endmodule

// File: rtl/hardsigmoid_backward.sv
// HardSigmoid backward pass: dx = dy/6 for -3 < x < 3, else 0, on a 3-stage
// pipeline that advances as a whole whenever the output slot can move.
// Also counts accepted outputs whose x lay inside the active range.
module hardsigmoid_backward
   import hardsigmoid_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   output logic                     ready_in,
   input  logic signed [DATA_W-1:0] x_data,
   input  logic signed [DATA_W-1:0] grad_data,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic signed [DATA_W-1:0] output_data,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         active_count
);

   localparam int COEF_W = 16;
   localparam logic signed [DATA_W-1:0] POS3 = DATA_W'(Q_POS3);
   localparam logic signed [DATA_W-1:0] NEG3 = DATA_W'(Q_NEG3);
   localparam logic [CNT_W-1:0]         CNT_MAX = {CNT_W{1'b1}};

   // Open interval test: exactly +/-3.0 is outside the active region
   function automatic logic in_open_range(input logic signed [DATA_W-1:0] x);
      return (x > NEG3) && (x < POS3);
   endfunction

   // Counter step that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic adv;
   logic out_hs;

   logic                     vld_p1, vld_p2, vld_p3;
   logic signed [DATA_W-1:0] dy_p1;
   logic                     mask_p1, mask_p2, mask_p3;
   logic signed [DATA_W-1:0] rnd_p2;
   logic signed [DATA_W-1:0] dx_p3;
   logic [CNT_W-1:0]         cnt_q;

   // The whole pipe moves together whenever the output slot is free or drained
   assign adv      = ~vld_p3 | ready_out;
   assign ready_in = adv;
   assign out_hs   = vld_p3 & ready_out;

   // ---- Input -> S1: register dy and the range mask
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (adv) begin
         vld_p1 <= valid_in;
      end
   end

   // S1 data capture; data registers carry no reset
   always_ff @(posedge clk) begin
      if (adv) begin
         dy_p1   <= grad_data;
         mask_p1 <= in_open_range(x_data);
      end
   end

   // ---- S1 -> S2: product register lives in the multiplier
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2 <= 1'b0;
      end else if (adv) begin
         vld_p2 <= vld_p1;
      end
   end

   // Carry the mask alongside the product
   always_ff @(posedge clk) begin
      if (adv) begin
         mask_p2 <= mask_p1;
      end
   end

   fxp_mul_round #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .FRAC_W (FRAC_W)
   ) u_mul (
      .clk    (clk),
      .en     (adv),
      .a_p1   (dy_p1),
      .coef   (INV6_Q16),
      .rnd_p2 (rnd_p2)
   );

   // ---- S2 -> S3: rounded, masked gradient
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p3 <= 1'b0;
      end else if (adv) begin
         vld_p3 <= vld_p2;
      end
   end

   // Out-of-range beats still flow through, carrying a zero gradient
   always_ff @(posedge clk) begin
      if (adv) begin
         dx_p3   <= mask_p2 ? rnd_p2 : '0;
         mask_p3 <= mask_p2;
      end
   end

   // Output gating keeps unreset data registers from leaking onto the bus
   assign valid_out   = vld_p3;
   assign output_data = vld_p3 ? dx_p3 : '0;

   // Profiling counter: clear has priority over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_q <= '0;
      end else if (out_hs && mask_p3) begin
         cnt_q <= sat_inc(cnt_q);
      end
   end

   assign active_count = cnt_q;

endmodule
